// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a synchronous imem.
//   imem_en    : read enable (fetch -> mem)
//   imem_addr  : byte address (fetch -> mem)
//   imem_rdata : read data, valid the cycle after imem_en (mem -> fetch)
interface fetch_stage_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Generates the PC and drives a 1-cycle-latency imem. While stall=0 it holds
// the IF/ID register and parks a returning word in a one-entry skid buffer. A
// redirect reloads the PC, kills the in-flight read and empties the skid, and
// turns IF/ID into a NOP.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   stall        : 1 = proceed, 0 = hold IF and IF/ID
//   redirect     : taken branch/jump pulse; redirect_pc is the target
//   imem         : instruction-memory bus (master side)
//   id_instr     : IF/ID instruction (0 when not valid)
//   id_pc4       : IF/ID PC+4 (0 when not valid)
//   id_valid     : IF/ID holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc4,
    output logic                 id_valid
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_ALN = RESET_PC & ALIGN_MASK;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc4;
    logic            skid_full;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc4;
    logic            issue_c;

    // A read is issued whenever the pipeline proceeds and no redirect is pending.
    assign issue_c        = rst_n & stall & ~redirect;
    assign imem.imem_en   = issue_c;
    assign imem.imem_addr = pc;

    // PC, in-flight tracking, skid buffer, IF/ID register and RUN/HOLD state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            pc           <= RESET_PC_ALN;
            inflight     <= 1'b0;
            inflight_pc4 <= '0;
            skid_full    <= 1'b0;
            skid_instr   <= '0;
            skid_pc4     <= '0;
            id_instr     <= '0;
            id_pc4       <= '0;
            id_valid     <= 1'b0;
        end else begin
            if (issue_c) begin
                pc           <= pc + PC_STEP;
                inflight     <= 1'b1;
                inflight_pc4 <= pc + PC_STEP;
            end else begin
                inflight     <= 1'b0;
            end

            if (redirect) begin
                // Overrides stall: drop everything younger than the branch.
                pc        <= redirect_pc & ALIGN_MASK;
                skid_full <= 1'b0;
                id_instr  <= '0;
                id_pc4    <= '0;
                id_valid  <= 1'b0;
                state     <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (stall) begin
                            if (inflight) begin
                                id_instr <= imem.imem_rdata;
                                id_pc4   <= inflight_pc4;
                                id_valid <= 1'b1;
                            end else begin
                                id_instr <= '0;
                                id_pc4   <= '0;
                                id_valid <= 1'b0;
                            end
                        end else begin
                            // Word returning during the stall is parked, not lost.
                            if (inflight) begin
                                skid_instr <= imem.imem_rdata;
                                skid_pc4   <= inflight_pc4;
                                skid_full  <= 1'b1;
                            end
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (stall) begin
                            if (skid_full) begin
                                id_instr  <= skid_instr;
                                id_pc4    <= skid_pc4;
                                id_valid  <= 1'b1;
                                skid_full <= 1'b0;
                            end else begin
                                id_instr <= '0;
                                id_pc4   <= '0;
                                id_valid <= 1'b0;
                            end
                            state <= RUN;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an address-as-data imem, a queue-based model of
// fetched-but-undelivered words checked every cycle, plus literal checks.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] id_instr, id_pc4;
    logic        id_valid;

    logic        rst_n2 = 1'b0;
    logic        stall2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] id_instr2, id_pc42;
    logic        id_valid2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage_if bus1();
    fetch_stage_if bus2();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus1),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem(bus2),
        .id_instr(id_instr2), .id_pc4(id_pc42), .id_valid(id_valid2)
    );

    // Synchronous imems returning the address as data.
    always @(posedge clk) if (bus1.imem_en) bus1.imem_rdata <= bus1.imem_addr;
    always @(posedge clk) if (bus2.imem_en) bus2.imem_rdata <= bus2.imem_addr;

    // Model: the PC, the fetched words not yet handed to decode, and IF/ID.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] a;
        if (!rst_n) begin
            m_pc = 32'h0;
            m_q.delete();
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_q.delete();
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
            if (m_q.size() > 0) begin
                a = m_q.pop_front();
                m_instr = a; m_pc4 = a + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("imem_en", 32'(bus1.imem_en), 32'(rst_n & stall & ~redirect));
        chk("imem_addr", bus1.imem_addr, m_pc);
        chk("id_instr", id_instr, m_instr);
        chk("id_pc4", id_pc4, m_pc4);
        chk("id_valid", 32'(id_valid), 32'(m_valid));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [0:17]  st_bits = 18'b101001110110111111;
    logic [0:17]  rd_bits = 18'b000000101000010000;
    logic [31:0]  tgt [0:17] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h1000, 32'h0, 32'h2002, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        cyc(2);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_en", 32'(bus1.imem_en), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("lit_first_en", 32'(bus1.imem_en), 32'h1);
        chk("lit_first_addr", bus1.imem_addr, 32'h0);
        cyc(1);
        chk("lit_addr4", bus1.imem_addr, 32'h4);
        chk("lit_no_valid_yet", 32'(id_valid), 32'h0);
        cyc(1);
        chk("lit_first_instr", id_instr, 32'h0);
        chk("lit_first_valid", 32'(id_valid), 32'h1);
        chk("lit_first_pc4", id_pc4, 32'h4);
        cyc(1);
        chk("lit_second_instr", id_instr, 32'h4);
        cyc(2);
        chk("lit_pre_stall_instr", id_instr, 32'hC);
        chk("lit_pre_stall_addr", bus1.imem_addr, 32'h14);
        stall = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("lit_stall_hold", id_instr, 32'hC);
            chk("lit_stall_pc", bus1.imem_addr, 32'h14);
        end
        stall = 1'b1;
        cyc(1);
        chk("lit_skid_out", id_instr, 32'h10);
        cyc(1);
        chk("lit_after_skid", id_instr, 32'h14);
        chk("lit_after_skid_pc4", id_pc4, 32'h18);
        cyc(2);
        chk("lit_pre_redir", id_instr, 32'h1C);
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc(1);
        redirect = 1'b0;
        chk("lit_redir_nop", id_instr, 32'h0);
        chk("lit_redir_valid", 32'(id_valid), 32'h0);
        chk("lit_redir_pc", bus1.imem_addr, 32'h200);
        cyc(2);
        chk("lit_target", id_instr, 32'h200);
        chk("lit_target_pc4", id_pc4, 32'h204);
        stall = 1'b0;
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h403;
        cyc(1);
        redirect = 1'b0;
        chk("lit_misalign_pc", bus1.imem_addr, 32'h400);
        chk("lit_misalign_nop", 32'(id_valid), 32'h0);
        cyc(1);
        stall = 1'b1;
        cyc(1);
        chk("lit_skid_dropped", 32'(id_valid), 32'h0);
        cyc(1);
        chk("lit_400", id_instr, 32'h400);
        stall = 1'b0;
        cyc(2);
        rst_n = 1'b0; stall = 1'b1;
        #1;
        chk("lit_async_instr", id_instr, 32'h0);
        chk("lit_async_pc4", id_pc4, 32'h0);
        chk("lit_async_valid", 32'(id_valid), 32'h0);
        chk("lit_async_en", 32'(bus1.imem_en), 32'h0);
        chk("lit_async_addr", bus1.imem_addr, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("lit_restart_instr", id_instr, 32'h0);
        chk("lit_restart_pc4", id_pc4, 32'h4);
        cyc(1);
        chk("lit_restart_next", id_instr, 32'h4);

        chk("lit2_rst_addr", bus2.imem_addr, 32'hFFFF_FFF8);
        rst_n2 = 1'b1;
        #1;
        chk("lit2_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        cyc(1);
        chk("lit2_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("lit2_addr_wrap", bus2.imem_addr, 32'h0);
        chk("lit2_instr0", id_instr2, 32'hFFFF_FFF8);
        chk("lit2_pc4_0", id_pc42, 32'hFFFF_FFFC);
        cyc(1);
        chk("lit2_instr1", id_instr2, 32'hFFFF_FFFC);
        chk("lit2_pc4_wrap", id_pc42, 32'h0);
        chk("lit2_valid1", 32'(id_valid2), 32'h1);

        for (int i = 0; i < 18; i++) begin
            stall = st_bits[i];
            redirect = rd_bits[i];
            redirect_pc = tgt[i];
            cyc(1);
        end
        redirect = 1'b0; stall = 1'b1;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
